// File: rtl/calc_pi_mc.sv
// Monte-Carlo pi estimator: two 32-bit LFSRs feed a 3-stage square/compare
// pipeline whose hit ratio over 2^LOG2_SAMPLES samples is published as Q6.23.
module calc_pi_mc #(
  parameter int unsigned LOG2_SAMPLES = 18,
  parameter logic [31:0] X_SEED       = 32'hACE12468,
  parameter logic [31:0] Y_SEED       = 32'h1357BDF9
) (
  input  logic        clk,
  input  logic        rst,
  output logic [28:0] pi_out
);

  localparam int unsigned CW    = LOG2_SAMPLES + 1;
  localparam int unsigned SHIFT = 25 - LOG2_SAMPLES;

  // Sixteen Fibonacci steps of x^32+x^22+x^2+x+1, flattened into one clock.
  function automatic logic [31:0] lfsr_adv16(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 16; i++) begin
      r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    end
    return r;
  endfunction

  logic [31:0]             x_lfsr_q, x_lfsr_d, y_lfsr_q, y_lfsr_d;
  logic [15:0]             x_q, x_d, y_q, y_d;
  logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [31:0]             xx_q, xx_d, yy_q, yy_d;
  logic                    hit_q, hit_d;
  logic [32:0]             sum;
  logic [CW-1:0]           hit_cnt_q, hit_cnt_d, hit_sum;
  logic [LOG2_SAMPLES-1:0] smp_cnt_q, smp_cnt_d;
  logic [28:0]             pi_q, pi_d;

  // NOTE: every signal gets a default at the top of the always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    x_lfsr_d  = lfsr_adv16(x_lfsr_q);
    y_lfsr_d  = lfsr_adv16(y_lfsr_q);
    x_d       = x_lfsr_d[15:0];
    y_d       = y_lfsr_d[15:0];
    v1_d      = 1'b1;
    xx_d      = {16'd0, x_q} * {16'd0, x_q};
    yy_d      = {16'd0, y_q} * {16'd0, y_q};
    v2_d      = v1_q;
    sum       = {1'b0, xx_q} + {1'b0, yy_q};
    hit_d     = ~sum[32];
    v3_d      = v2_q;
    hit_sum   = hit_cnt_q + CW'(hit_q);
    hit_cnt_d = hit_cnt_q;
    smp_cnt_d = smp_cnt_q;
    pi_d      = pi_q;
    if (v3_q) begin
      if (&smp_cnt_q) begin
        // Scaling by 4*2^23/N is a pure left shift because N is a power of two.
        pi_d      = 29'(hit_sum) << SHIFT;
        hit_cnt_d = '0;
        smp_cnt_d = '0;
      end else begin
        hit_cnt_d = hit_sum;
        smp_cnt_d = smp_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_lfsr_q  <= X_SEED;
      y_lfsr_q  <= Y_SEED;
      x_q       <= '0;
      y_q       <= '0;
      v1_q      <= 1'b0;
      xx_q      <= '0;
      yy_q      <= '0;
      v2_q      <= 1'b0;
      hit_q     <= 1'b0;
      v3_q      <= 1'b0;
      hit_cnt_q <= '0;
      smp_cnt_q <= '0;
      pi_q      <= '0;
    end else begin
      x_lfsr_q  <= x_lfsr_d;
      y_lfsr_q  <= y_lfsr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      v1_q      <= v1_d;
      xx_q      <= xx_d;
      yy_q      <= yy_d;
      v2_q      <= v2_d;
      hit_q     <= hit_d;
      v3_q      <= v3_d;
      hit_cnt_q <= hit_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      pi_q      <= pi_d;
    end
  end

  assign pi_out = pi_q;

endmodule

// File: tb/tb_calc_pi_mc.sv
// Bench for calc_pi_mc: two instances (1024- and 16-sample windows) checked
// every cycle against a sample-level software model of the estimator.
module tb_calc_pi_mc;

  localparam int LB   = 10;
  localparam int LS   = 4;
  localparam int NB   = 1 << LB;
  localparam int MAXC = 65600;
  localparam logic [31:0] XS = 32'hACE12468;
  localparam logic [31:0] YS = 32'h1357BDF9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [28:0] pi_big, pi_small;

  int errors = 0;
  int checks = 0;
  int prefix [0:MAXC];

  typedef struct {
    int          run_cycles;
    logic [28:0] exp_big;
    logic [28:0] exp_small;
  } vec_t;
  vec_t vecs [6];

  longint acc_sum = 0;
  int     acc_cnt = 0;

  calc_pi_mc #(.LOG2_SAMPLES(LB)) u_big   (.clk(clk), .rst(rst), .pi_out(pi_big));
  calc_pi_mc #(.LOG2_SAMPLES(LS)) u_small (.clk(clk), .rst(rst), .pi_out(pi_small));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] adv16(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 16; i++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    return r;
  endfunction

  // Expected output c clocks after release: last completed window's hits, scaled.
  function automatic logic [28:0] model_pi(input int c, input int l);
    int w, hits;
    if (c < 3) return '0;
    w = (c - 3) >> l;
    if (w == 0) return '0;
    hits = prefix[w << l] - prefix[(w - 1) << l];
    return 29'(longint'(hits) << (25 - l));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_big", pi_big, 0);
    check("async_reset_small", pi_small, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_big", pi_big, 0);
    check("reset_hold_small", pi_small, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int ncyc, input bit first);
    logic [31:0] mx, my;
    longint      d;
    mx = XS;
    my = YS;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      mx = adv16(mx);
      my = adv16(my);
      check("pi_big", pi_big, model_pi(c, LB));
      check("pi_small", pi_small, model_pi(c, LS));
      check("lfsr_x", u_big.x_lfsr_q, mx);
      check("lfsr_y", u_big.y_lfsr_q, my);
      check("lfsr_nonzero_distinct",
            (u_big.x_lfsr_q != 0) && (u_big.y_lfsr_q != 0) &&
            (u_big.x_lfsr_q != u_big.y_lfsr_q), 1);
      if (first && c >= NB + 3 && ((c - 3) % NB) == 0) begin
        if (c == NB + 3) begin
          d = longint'(pi_big) - 64'sd26353589;
          if (d < 0) d = -d;
          check("accuracy_first_window", d <= 2516582, 1);
        end
        acc_sum += longint'(pi_big);
        acc_cnt++;
      end
    end
  endtask

  initial begin
    logic [31:0] sx, sy;
    longint      xv, yv, d;
    sx = XS;
    sy = YS;
    prefix[0] = 0;
    for (int k = 1; k <= MAXC; k++) begin
      sx = adv16(sx);
      sy = adv16(sy);
      xv = longint'(sx[15:0]);
      yv = longint'(sy[15:0]);
      prefix[k] = prefix[k-1] + ((xv * xv + yv * yv < 64'sd4294967296) ? 1 : 0);
    end

    vecs[0].run_cycles = 65540;
    vecs[1].run_cycles = NB / 2 + 3;
    vecs[2].run_cycles = 2 * NB + 3;
    vecs[3].run_cycles = $urandom_range(3 * NB, NB + 3);
    vecs[4].run_cycles = NB + 2;
    vecs[5].run_cycles = NB + 3;
    foreach (vecs[i]) begin
      vecs[i].exp_big   = model_pi(vecs[i].run_cycles, LB);
      vecs[i].exp_small = model_pi(vecs[i].run_cycles, LS);
    end

    foreach (vecs[i]) begin
      do_reset();
      run(vecs[i].run_cycles, i == 0);
      check("end_of_run_big", pi_big, vecs[i].exp_big);
      check("end_of_run_small", pi_small, vecs[i].exp_small);
    end
    do_reset();

    check("accuracy_window_count", acc_cnt, (65540 - 3) / NB);
    if (acc_cnt > 0) begin
      d = acc_sum / acc_cnt - 64'sd26353589;
      if (d < 0) d = -d;
      check("accuracy_mean", d <= 419430, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
